adder_entry_ctrl: RTL and testbench
===================================

Name: adder_entry_ctrl

Overview:
- Key-driven sequencing controller for the two-operand 8-bit adder display path.
- Steps the user through three phases: enter operand A, enter operand B, show A+B.
- Drives a 9-bit binary value to the bin-to-BCD stage, plus a blink/blank flag for the digit driver.
- Sits between the debounced key pulses and the bin_to_bcd / seg_driver chain.

Parameters:
- BLINK_CNT, 25_000_000, sys_clk cycles per blink half-period. The default is 0.5 s at 50 MHz. Minimum value is 2.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous, active-low reset
- key_inc  input  1  one-cycle debounced pulse: increment the active operand
- key_dec  input  1  one-cycle debounced pulse: decrement the active operand
- key_next  input  1  one-cycle debounced pulse: advance to the next phase
- op_a  output  8  operand A register
- op_b  output  8  operand B register
- sum  output  9  latched A+B; bit 8 is the carry
- sum_valid  output  1  one-cycle pulse when sum is latched
- disp_bin  output  9  value to display, fed to bin_to_bcd
- disp_blank  output  1  1 = seg_driver blanks all digits (blink off-phase)
- mode  output  2  current phase: 00 = ENTER_A, 01 = ENTER_B, 10 = SHOW_SUM

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state = ENTER_A, op_a = 0, op_b = 0, sum = 0, sum_valid = 0.
  - disp_bin = 0, disp_blank = 0, blink counter = 0, blink phase = 0.
- Encoding 11 is unused; if reached, go to ENTER_A on the next clock.
- Key priority within one cycle: key_next first. If key_next = 1, inc/dec are ignored that cycle.
- If key_inc and key_dec are both 1 and key_next = 0: no operand change, but the blink is still restarted.
- ENTER_A:
  - inc: op_a <= op_a+1, wrapping 255->0.
  - dec: op_a <= op_a-1, wrapping 0->255.
  - next: go to ENTER_B.
- ENTER_B:
  - inc/dec act on op_b with the same wrap rules.
  - next: go to SHOW_SUM, latch sum <= {1'b0,op_a}+{1'b0,op_b}, and assert sum_valid for exactly that one cycle (registered, same edge as the state change).
- SHOW_SUM:
  - inc/dec ignored.
  - next: go to ENTER_A. op_a, op_b and sum are all retained, so the user can re-edit and re-sum.
- disp_bin is a registered function of the current state: ENTER_A -> {0,op_a}, ENTER_B -> {0,op_b}, SHOW_SUM -> sum.
  - Latency: disp_bin reflects an operand change or state change one clock after the register update.
  - This is two edges after the key pulse.
- Blink (only in ENTER_A and ENTER_B):
  - The counter runs 0..BLINK_CNT-1. On reaching BLINK_CNT-1 it wraps to 0 and toggles the phase.
  - disp_blank = phase, registered.
- Blink restart: any key_inc, key_dec or key_next pulse clears the counter and the phase on the next edge, so the edited value is shown immediately.
- In SHOW_SUM the counter is held at 0 and disp_blank = 0 (steady display).
- Counter width is $clog2(BLINK_CNT). There is no other free-running logic.

Test Plan (BLINK_CNT = 4 for simulation):
- Reset release, no keys:
  - mode = 00, disp_bin = 0.
  - disp_blank toggles every 4 cycles: 0,0,0,0,1,1,1,1,...
- ENTER_A, 3 inc then 1 dec:
  - op_a = 2, disp_bin = 2.
  - Each pulse forces disp_blank = 0 and restarts the 4-cycle count.
- dec at op_a = 0 -> op_a = 255. Then inc -> op_a = 0 (both wraps).
- Full sequence:
  - Set op_a = 200, next, set op_b = 100, next.
  - Required: mode = 10, sum = 300 (9'h12C, carry = 1), sum_valid high for exactly 1 cycle, disp_bin = 300, disp_blank = 0.
  - inc/dec pulses in this state leave all values unchanged.
- Simultaneous pulses:
  - key_next + key_inc in ENTER_A: mode -> 01, op_a unchanged.
  - key_inc + key_dec in ENTER_B: op_b unchanged, blink restarted.
- Next from SHOW_SUM:
  - Returns to mode 00 with op_a = 200, op_b = 100, sum = 300 retained.
- Reset asserted mid-blink in ENTER_B:
  - All outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/adder_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_entry_ctrl
// Purpose  : Key-driven sequencing controller for the two-operand 8-bit adder
//            display path. Walks the user through ENTER_A -> ENTER_B ->
//            SHOW_SUM, and produces the 9-bit value for bin_to_bcd plus a
//            blink/blank flag for seg_driver.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   sys_clk     in   1  system clock
//   sys_rst_n   in   1  asynchronous, active-low reset
//   key_inc     in   1  debounced pulse: increment active operand
//   key_dec     in   1  debounced pulse: decrement active operand
//   key_next    in   1  debounced pulse: advance to next phase
//   op_a        out  8  operand A register
//   op_b        out  8  operand B register
//   sum         out  9  latched A+B, bit 8 = carry
//   sum_valid   out  1  one-cycle pulse when sum is latched
//   disp_bin    out  9  value to display
//   disp_blank  out  1  1 = blank all digits (blink off-phase)
//   mode        out  2  00 ENTER_A, 01 ENTER_B, 10 SHOW_SUM
// ============================================================================
module adder_entry_ctrl #(
    parameter int BLINK_CNT = 25_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       key_next,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic [8:0] sum,
    output logic       sum_valid,
    output logic [8:0] disp_bin,
    output logic       disp_blank,
    output logic [1:0] mode
);

    localparam int               CNT_W   = $clog2(BLINK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'b00,
        ST_ENTER_B  = 2'b01,
        ST_SHOW_SUM = 2'b10,
        ST_UNUSED   = 2'b11
    } state_t;

    state_t           state_q,      state_d;
    logic [7:0]       op_a_q,       op_a_d;
    logic [7:0]       op_b_q,       op_b_d;
    logic [8:0]       sum_q,        sum_d;
    logic             sum_valid_q,  sum_valid_d;
    logic [8:0]       disp_bin_q,   disp_bin_d;
    logic [CNT_W-1:0] blink_cnt_q,  blink_cnt_d;
    logic             blink_ph_q,   blink_ph_d;

    // key_next wins; inc and dec together cancel each other.
    logic w_do_inc;
    logic w_do_dec;
    logic w_any_key;

    assign w_do_inc  = key_inc & ~key_dec & ~key_next;
    assign w_do_dec  = key_dec & ~key_inc & ~key_next;
    assign w_any_key = key_inc | key_dec | key_next;

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        disp_bin_d  = 9'd0;
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;

        case (state_q)
            ST_ENTER_A: begin
                if (key_next)      state_d = ST_ENTER_B;
                else if (w_do_inc) op_a_d  = op_a_q + 8'd1;
                else if (w_do_dec) op_a_d  = op_a_q - 8'd1;
            end
            ST_ENTER_B: begin
                if (key_next) begin
                    state_d     = ST_SHOW_SUM;
                    sum_d       = {1'b0, op_a_q} + {1'b0, op_b_q};
                    sum_valid_d = 1'b1;
                end else if (w_do_inc) begin
                    op_b_d = op_b_q + 8'd1;
                end else if (w_do_dec) begin
                    op_b_d = op_b_q - 8'd1;
                end
            end
            ST_SHOW_SUM: begin
                if (key_next) state_d = ST_ENTER_A;
            end
            default: state_d = ST_ENTER_A;
        endcase

        // Display follows the current (registered) state, so it trails the
        // operand/state registers by one clock.
        case (state_q)
            ST_ENTER_A:  disp_bin_d = {1'b0, op_a_q};
            ST_ENTER_B:  disp_bin_d = {1'b0, op_b_q};
            ST_SHOW_SUM: disp_bin_d = sum_q;
            default:     disp_bin_d = 9'd0;
        endcase

        // Blink only while editing; any key restarts it in the visible phase.
        // Outside the edit phases both stay at their cleared defaults.
        if (((state_q == ST_ENTER_A) || (state_q == ST_ENTER_B)) && !w_any_key) begin
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_ONE;
                blink_ph_d  = blink_ph_q;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_ENTER_A;
            op_a_q      <= 8'd0;
            op_b_q      <= 8'd0;
            sum_q       <= 9'd0;
            sum_valid_q <= 1'b0;
            disp_bin_q  <= 9'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            disp_bin_q  <= disp_bin_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign sum        = sum_q;
    assign sum_valid  = sum_valid_q;
    assign disp_bin   = disp_bin_q;
    assign disp_blank = blink_ph_q;
    assign mode       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_entry_ctrl
// Purpose  : Self-checking bench for adder_entry_ctrl (BLINK_CNT = 4).
//            A phase/operand model runs alongside the DUT and is compared on
//            every falling clock edge; literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_entry_ctrl;

    localparam int BLINK = 4;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_inc   = 1'b0;
    logic       key_dec   = 1'b0;
    logic       key_next  = 1'b0;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [8:0] sum;
    logic       sum_valid;
    logic [8:0] disp_bin;
    logic       disp_blank;
    logic [1:0] mode;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    adder_entry_ctrl #(.BLINK_CNT(BLINK)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_inc    (key_inc),
        .key_dec    (key_dec),
        .key_next   (key_next),
        .op_a       (op_a),
        .op_b       (op_b),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .disp_bin   (disp_bin),
        .disp_blank (disp_blank),
        .mode       (mode)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural model ----------------
    // phase: 0 = enter A, 1 = enter B, 2 = show sum
    int m_ph    = 0;
    int m_a     = 0;
    int m_b     = 0;
    int m_s     = 0;
    int m_sv    = 0;
    int m_disp  = 0;
    int m_since = 0;   // edges since the last blink restart

    initial begin
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) begin
                m_ph = 0; m_a = 0; m_b = 0; m_s = 0; m_sv = 0;
                m_disp = 0; m_since = 0;
            end else begin
                int shown;
                int old_ph;
                shown  = (m_ph == 0) ? m_a : (m_ph == 1) ? m_b : m_s;
                old_ph = m_ph;
                m_sv   = 0;
                if (key_next) begin
                    if (m_ph == 1) begin
                        m_s  = m_a + m_b;
                        m_sv = 1;
                    end
                    m_ph = (m_ph + 1) % 3;
                end else if (key_inc != key_dec && m_ph != 2) begin
                    if (m_ph == 0) m_a = (m_a + (key_inc ? 1 : 255)) % 256;
                    else           m_b = (m_b + (key_inc ? 1 : 255)) % 256;
                end
                if (old_ph == 2 || key_inc || key_dec || key_next) m_since = 0;
                else                                              m_since = m_since + 1;
                m_disp = shown;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge sys_clk) begin
        if (chk_en && sys_rst_n) begin
            chk("cyc_mode",  int'(mode),       m_ph);
            chk("cyc_op_a",  int'(op_a),       m_a);
            chk("cyc_op_b",  int'(op_b),       m_b);
            chk("cyc_sum",   int'(sum),        m_s);
            chk("cyc_sv",    int'(sum_valid),  m_sv);
            chk("cyc_disp",  int'(disp_bin),   m_disp);
            chk("cyc_blank", int'(disp_blank), (m_ph == 2) ? 0 : ((m_since / BLINK) % 2));
        end
    end

    // One-edge key pulse; returns at 1 time unit after the capturing edge.
    task automatic pulse(input logic i, input logic d, input logic n);
        @(posedge sys_clk); #1;
        key_inc = i; key_dec = d; key_next = n;
        @(posedge sys_clk); #1;
        key_inc = 1'b0; key_dec = 1'b0; key_next = 1'b0;
    endtask

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    initial begin
        int r;
        int guard;
        bit [7:0] exp_blink;
        exp_blink = 8'b1111_0000;   // bit k = expected blank at sample k

        // Reset release, no keys
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        chk_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge sys_clk);
            chk("rst_blink", int'(disp_blank), int'(exp_blink[k]));
        end
        chk("rst_mode", int'(mode), 0);
        chk("rst_disp", int'(disp_bin), 0);

        // 3 inc, 1 dec
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 1, 0);
        chk("edit_op_a", int'(op_a), 2);
        chk("edit_blank", int'(disp_blank), 0);
        tick();
        chk("edit_disp", int'(disp_bin), 2);

        // Wraps
        pulse(0, 1, 0); pulse(0, 1, 0); pulse(0, 1, 0);
        chk("wrap_down", int'(op_a), 255);
        pulse(1, 0, 0);
        chk("wrap_up", int'(op_a), 0);

        // op_a = 200, op_b = 100
        repeat (56) pulse(0, 1, 0);
        chk("set_a", int'(op_a), 200);
        pulse(0, 0, 1);
        repeat (100) pulse(1, 0, 0);
        chk("set_b", int'(op_b), 100);
        repeat (6) tick();
        pulse(1, 1, 0);
        chk("incdec_b", int'(op_b), 100);
        chk("incdec_blank", int'(disp_blank), 0);

        pulse(0, 0, 1);
        chk("sum_mode", int'(mode), 2);
        chk("sum_val", int'(sum), 300);
        chk("sum_valid_hi", int'(sum_valid), 1);
        tick();
        chk("sum_valid_lo", int'(sum_valid), 0);
        chk("sum_disp", int'(disp_bin), 300);
        chk("sum_blank", int'(disp_blank), 0);
        pulse(1, 0, 0); pulse(0, 1, 0);
        repeat (6) tick();
        chk("show_hold_a", int'(op_a), 200);
        chk("show_hold_b", int'(op_b), 100);
        chk("show_hold_s", int'(sum), 300);
        chk("show_disp", int'(disp_bin), 300);
        chk("show_blank", int'(disp_blank), 0);

        // Back to ENTER_A with values retained
        pulse(0, 0, 1);
        chk("ret_mode", int'(mode), 0);
        chk("ret_a", int'(op_a), 200);
        chk("ret_b", int'(op_b), 100);
        chk("ret_s", int'(sum), 300);

        // next + inc together
        pulse(1, 0, 1);
        chk("nxtinc_mode", int'(mode), 1);
        chk("nxtinc_a", int'(op_a), 200);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge sys_clk); #1;
            r = int'($urandom_range(0, 15));
            key_inc  = (r == 1) || (r == 3) || (r == 5);
            key_dec  = (r == 2) || (r == 3) || (r == 6);
            key_next = (r == 4);
        end
        @(posedge sys_clk); #1;
        key_inc = 1'b0; key_dec = 1'b0; key_next = 1'b0;

        // Async reset mid-blink in ENTER_B
        guard = 0;
        while (m_ph != 1 && guard < 4) begin
            pulse(0, 0, 1);
            guard++;
        end
        if (m_ph != 1) chk("reach_enter_b", m_ph, 1);
        pulse(1, 0, 0);
        repeat (5) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_mode",  int'(mode),       0);
        chk("arst_op_a",  int'(op_a),       0);
        chk("arst_op_b",  int'(op_b),       0);
        chk("arst_sum",   int'(sum),        0);
        chk("arst_sv",    int'(sum_valid),  0);
        chk("arst_disp",  int'(disp_bin),   0);
        chk("arst_blank", int'(disp_blank), 0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
